// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter onto an APB bus with two slaves (GPIO, UART).
// Handles one transfer at a time, with a wait-state timeout and an error response for bad selects.
module apb_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_sel,
  input  logic [1:0]  req_write,
  input  logic [9:0]  req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [31:0] rdata,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [4:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2
);

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SEL_W-1:0] SEL_GPIO = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_UART = SEL_W'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  state_e             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               ptr_q, ptr_d;
  xfer_t              xfer_q, xfer_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               psel1_q, psel1_d;
  logic               psel2_q, psel2_d;
  logic               penable_q, penable_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               pick;
  xfer_t              cand;
  logic               cand_ok;
  logic               pready_sel;
  logic [DATA_W-1:0]  prdata_sel;
  logic               timed_out;

  // Round-robin choice: on contention the requester that did not complete last wins.
  always_comb begin
    if (req_valid == 2'b11) begin
      pick = ~ptr_q;
    end else begin
      pick = ~req_valid[0];
    end
    cand.sel   = pick ? req_sel[3:2]    : req_sel[1:0];
    cand.write = pick ? req_write[1]    : req_write[0];
    cand.addr  = pick ? req_addr[9:5]   : req_addr[4:0];
    cand.wdata = pick ? req_wdata[63:32] : req_wdata[31:0];
    cand_ok    = (cand.sel == SEL_GPIO) || (cand.sel == SEL_UART);
  end

  // Only the latched slave's handshake is observed.
  always_comb begin
    pready_sel = (xfer_q.sel == SEL_GPIO) ? PREADY1 : PREADY2;
    prdata_sel = (xfer_q.sel == SEL_GPIO) ? PRDATA1 : PRDATA2;
    timed_out  = (wait_q == CNT_W'(TIMEOUT - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    xfer_d    = xfer_q;
    wait_d    = wait_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    done_d    = '0;
    err_d     = '0;
    rdata_d   = '0;

    case (state_q)
      IDLE: begin
        if ((|req_valid) && (done_q == '0)) begin
          gnt_d  = pick;
          xfer_d = cand;
          wait_d = '0;
          if (cand_ok) begin
            psel1_d = (cand.sel == SEL_GPIO);
            psel2_d = (cand.sel == SEL_UART);
            state_d = SETUP;
          end else begin
            // Bad select never reaches the bus; complete with error immediately.
            done_d[pick] = 1'b1;
            err_d[pick]  = 1'b1;
            ptr_d        = pick;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (pready_sel || timed_out) begin
          state_d       = IDLE;
          psel1_d       = 1'b0;
          psel2_d       = 1'b0;
          penable_d     = 1'b0;
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = ~pready_sel;
          ptr_d         = gnt_q;
          if (pready_sel && !xfer_q.write) begin
            rdata_d = prdata_sel;
          end
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      ptr_q     <= 1'b1;
      xfer_q    <= '0;
      wait_q    <= '0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      xfer_q    <= xfer_d;
      wait_q    <= wait_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign req_done = done_q;
  assign req_err  = err_q;
  assign rdata    = rdata_q;
  assign PSEL1    = psel1_q;
  assign PSEL2    = psel2_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = xfer_q.write;
  assign PADDR    = xfer_q.addr;
  assign PWDATA   = xfer_q.wdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios then randomized rounds, each checked
// against a transaction-level model of the arbitration, timing and response rules.
module tb_apb_arbiter;

  localparam int unsigned TIMEOUT = 15;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [3:0]  req_sel;
  logic [1:0]  req_write;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [31:0] rdata;
  logic        PSEL1, PSEL2, PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY1, PREADY2;
  logic [31:0] PRDATA1, PRDATA2;

  apb_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_sel(req_sel), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .rdata(rdata),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side model: pending flag and payload per requester, plus last completed grant.
  bit          pend   [2];
  logic [1:0]  p_sel  [2];
  logic        p_wr   [2];
  logic [4:0]  p_addr [2];
  logic [31:0] p_wd   [2];
  int          last_gnt = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    req_valid = {pend[1], pend[0]};
    req_sel   = {p_sel[1], p_sel[0]};
    req_write = {p_wr[1], p_wr[0]};
    req_addr  = {p_addr[1], p_addr[0]};
    req_wdata = {p_wd[1], p_wd[0]};
  endtask

  task automatic set_req(input int i, input logic [1:0] sel, input logic wr,
                         input logic [4:0] a, input logic [31:0] d);
    pend[i]   = 1'b1;
    p_sel[i]  = sel;
    p_wr[i]   = wr;
    p_addr[i] = a;
    p_wd[i]   = d;
  endtask

  task automatic rand_req(input int i);
    int r;
    logic [1:0] s;
    r = $urandom_range(0, 9);
    s = (r < 4) ? 2'd1 : ((r < 8) ? 2'd2 : ((r == 8) ? 2'd0 : 2'd3));
    set_req(i, s, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
  endtask

  task automatic randomize_slaves();
    PREADY1 = 1'($urandom_range(0, 1));
    PREADY2 = 1'($urandom_range(0, 1));
    PRDATA1 = $urandom;
    PRDATA2 = $urandom;
  endtask

  // One complete transaction from the current negedge (DUT idle) through the idle gap.
  task automatic do_round(input int stall, input bit fix, input logic [31:0] fix_val);
    int          g;
    int          kf;
    bit          ok;
    logic [1:0]  sel;
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] prd;
    logic [1:0]  gbit;
    drive_reqs();
    if (pend[0] && pend[1]) g = 1 - last_gnt;
    else                    g = pend[0] ? 0 : 1;
    sel  = p_sel[g];
    wr   = p_wr[g];
    a    = p_addr[g];
    d    = p_wd[g];
    gbit = (g == 0) ? 2'b01 : 2'b10;
    prd  = '0;
    @(negedge PCLK);
    if (sel == 2'd1 || sel == 2'd2) begin
      check("setup_sel", 64'({PSEL1, PSEL2, PENABLE}), 64'({sel == 2'd1, sel == 2'd2, 1'b0}));
      check("setup_addr", 64'({PWRITE, PADDR, PWDATA}), 64'({wr, a, d}));
      check("setup_done", 64'({req_done, req_err}), 64'(0));
      // The granted requester may drop or change its lines; the latched transfer must not care.
      if ($urandom_range(0, 1) == 1) begin
        pend[g]   = 1'($urandom_range(0, 1));
        p_sel[g]  = 2'($urandom);
        p_wr[g]   = 1'($urandom);
        p_addr[g] = 5'($urandom);
        p_wd[g]   = $urandom;
        drive_reqs();
      end
      randomize_slaves();
      ok = (stall < int'(TIMEOUT));
      kf = ok ? stall : int'(TIMEOUT) - 1;
      for (int k = 0; k <= kf; k++) begin
        @(negedge PCLK);
        check("access_sel", 64'({PSEL1, PSEL2, PENABLE}), 64'({sel == 2'd1, sel == 2'd2, 1'b1}));
        check("access_addr", 64'({PWRITE, PADDR, PWDATA}), 64'({wr, a, d}));
        check("access_done", 64'({req_done, req_err}), 64'(0));
        randomize_slaves();
        prd = fix ? fix_val : $urandom;
        if (sel == 2'd1) begin
          PREADY1 = (k == stall);
          PRDATA1 = prd;
        end else begin
          PREADY2 = (k == stall);
          PRDATA2 = prd;
        end
      end
      @(negedge PCLK);
      check("done", 64'(req_done), 64'(gbit));
      check("err", 64'(req_err), ok ? 64'(0) : 64'(gbit));
      check("rdata", 64'(rdata), (ok && !wr) ? 64'(prd) : 64'(0));
      check("done_bus", 64'({PSEL1, PSEL2, PENABLE}), 64'(0));
    end else begin
      check("inv_done", 64'(req_done), 64'(gbit));
      check("inv_err", 64'(req_err), 64'(gbit));
      check("inv_bus", 64'({PSEL1, PSEL2, PENABLE, rdata}), 64'(0));
    end
    pend[g]  = 1'b0;
    last_gnt = g;
    drive_reqs();
    randomize_slaves();
    @(negedge PCLK);
    check("gap", 64'({PSEL1, PSEL2, PENABLE, req_done, req_err}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; p_sel[i] = '0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
    end
    PRESET = 1'b1;
    drive_reqs();
    randomize_slaves();
    repeat (3) @(negedge PCLK);
    check("reset_bus", 64'({PSEL1, PSEL2, PENABLE, PWRITE, PADDR}), 64'(0));
    check("reset_resp", 64'({req_done, req_err, rdata}), 64'(0));
    check("reset_wdata", 64'(PWDATA), 64'(0));
    PRESET = 1'b0;

    // Contention for three rounds: grants 0, 1, 0.
    set_req(0, 2'd1, 1'b1, 5'd3, 32'h1111_0000);
    set_req(1, 2'd2, 1'b0, 5'd7, 32'h2222_0000);
    do_round(0, 1'b0, '0);
    set_req(0, 2'd2, 1'b1, 5'd9, 32'h3333_0000);
    do_round(1, 1'b0, '0);
    set_req(1, 2'd1, 1'b0, 5'd1, 32'h4444_0000);
    do_round(0, 1'b0, '0);
    do_round(2, 1'b0, '0);

    // Zero-wait GPIO write, UART read with waits, timeout abort, invalid select.
    set_req(0, 2'd1, 1'b1, 5'd4, 32'hA5A5_0001);
    do_round(0, 1'b0, '0);
    set_req(1, 2'd2, 1'b0, 5'd2, 32'h0);
    do_round(3, 1'b1, 32'h0000_00C3);
    set_req(0, 2'd1, 1'b0, 5'd6, 32'h0);
    do_round(100, 1'b0, '0);
    set_req(0, 2'd3, 1'b1, 5'd8, 32'hDEAD_BEEF);
    do_round(0, 1'b0, '0);
    set_req(1, 2'd0, 1'b0, 5'd8, 32'h0);
    do_round(0, 1'b0, '0);

    // Reset in the middle of an ACCESS phase.
    set_req(0, 2'd1, 1'b1, 5'd10, 32'h5555_AAAA);
    set_req(1, 2'd2, 1'b0, 5'd11, 32'h0);
    drive_reqs();
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_rst_access", 64'(PENABLE), 64'(1));
    PREADY1 = 1'b0;
    PREADY2 = 1'b0;
    PRESET  = 1'b1;
    @(negedge PCLK);
    check("rst_mid_bus", 64'({PSEL1, PSEL2, PENABLE, req_done, req_err}), 64'(0));
    check("rst_mid_rdata", 64'(rdata), 64'(0));
    PRESET   = 1'b0;
    last_gnt = 1;
    do_round(0, 1'b0, '0);

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) rand_req(i);
      end
      if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(0, 1)));
      do_round(($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20))
                                           : int'($urandom_range(0, 4)), 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
